// File: rtl/bootstrap_memory_copier.sv
// Boot-time copy engine: walks every EEPROM address, strobing RAM to capture the
// byte the EEPROM drives onto the shared data bus, then parks with done high.
module bootstrap_memory_copier #(
  parameter int EEPROM_ADDRESS_BUS_WIDTH = 13
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [15:0] address,
  output logic        ram_we_n,
  output logic        ram_cs_n,
  output logic        eeprom_oe_n,
  output logic        eeprom_cs_n,
  output logic        done
);

  localparam int W = EEPROM_ADDRESS_BUS_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WRITE,
    HOLD,
    NEXT,
    DONE
  } state_t;

  state_t         state, state_nx;
  logic [W-1:0]   count, count_nx;
  logic [15:0]    address_nx;
  logic           ram_we_nx, ram_cs_nx, eeprom_oe_nx, eeprom_cs_nx, done_nx;

  // Outputs are decoded from the *next* state and registered alongside it, so
  // every bus/strobe line comes straight out of a flop with no decode glitches.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_nx     = state;
    count_nx     = count;
    address_nx   = '0;
    ram_we_nx    = 1'b1;
    ram_cs_nx    = 1'b1;
    eeprom_oe_nx = 1'b1;
    eeprom_cs_nx = 1'b1;
    done_nx      = 1'b0;

    case (state)
      IDLE:  begin
        state_nx = SETUP;
        count_nx = '0;
      end
      SETUP: state_nx = WRITE;
      WRITE: state_nx = HOLD;
      HOLD:  state_nx = NEXT;
      NEXT:  begin
        if (count == '1) begin
          state_nx = DONE;
        end else begin
          state_nx = SETUP;
          count_nx = count + W'(1);
        end
      end
      DONE:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase

    case (state_nx)
      SETUP: begin
        address_nx   = 16'(count_nx);
        eeprom_cs_nx = 1'b0;
        eeprom_oe_nx = 1'b0;
      end
      WRITE: begin
        address_nx   = 16'(count_nx);
        eeprom_cs_nx = 1'b0;
        eeprom_oe_nx = 1'b0;
        ram_cs_nx    = 1'b0;
        ram_we_nx    = 1'b0;
      end
      // WE has risen but both chips stay selected so RAM sees stable data past the edge.
      HOLD: begin
        address_nx   = 16'(count_nx);
        eeprom_cs_nx = 1'b0;
        eeprom_oe_nx = 1'b0;
        ram_cs_nx    = 1'b0;
      end
      NEXT:    address_nx = 16'(count_nx);
      DONE:    done_nx    = 1'b1;
      default: ;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so all registers update
  // together from values sampled at the same edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      count       <= '0;
      address     <= '0;
      ram_we_n    <= 1'b1;
      ram_cs_n    <= 1'b1;
      eeprom_oe_n <= 1'b1;
      eeprom_cs_n <= 1'b1;
      done        <= 1'b0;
    end else begin
      state       <= state_nx;
      count       <= count_nx;
      address     <= address_nx;
      ram_we_n    <= ram_we_nx;
      ram_cs_n    <= ram_cs_nx;
      eeprom_oe_n <= eeprom_oe_nx;
      eeprom_cs_n <= eeprom_cs_nx;
      done        <= done_nx;
    end
  end

endmodule

// File: tb/tb_bootstrap_memory_copier.sv
// Self-checking bench: W=4 and W=1 copiers; per-cycle outputs checked against a
// timing table, and RAM write addresses checked against a queued scoreboard.
module tb_bootstrap_memory_copier;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst4_n, rst1_n;
  logic [15:0] addr4, addr1;
  logic        we4, cs4, oe4, ecs4, done4;
  logic        we1, cs1, oe1, ecs1, done1;

  bootstrap_memory_copier #(.EEPROM_ADDRESS_BUS_WIDTH(4)) dut4 (
    .clock(clock), .reset_n(rst4_n), .address(addr4), .ram_we_n(we4),
    .ram_cs_n(cs4), .eeprom_oe_n(oe4), .eeprom_cs_n(ecs4), .done(done4)
  );

  bootstrap_memory_copier #(.EEPROM_ADDRESS_BUS_WIDTH(1)) dut1 (
    .clock(clock), .reset_n(rst1_n), .address(addr1), .ram_we_n(we1),
    .ram_cs_n(cs1), .eeprom_oe_n(oe1), .eeprom_cs_n(ecs1), .done(done1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
  endtask

  // Expected {done, eeprom_cs_n, eeprom_oe_n, ram_cs_n, ram_we_n, address} after
  // edge E(t); t < 0 means the edge sampled reset low.
  function automatic logic [20:0] exp_outs(input int t, input int n);
    int k, ph;
    if (t < 0)      return {1'b0, 4'b1111, 16'h0000};
    if (t >= 4 * n) return {1'b1, 4'b1111, 16'h0000};
    k  = t / 4;
    ph = t % 4;
    case (ph)
      0:       return {1'b0, 4'b0011, 16'(k)};
      1:       return {1'b0, 4'b0000, 16'(k)};
      2:       return {1'b0, 4'b0001, 16'(k)};
      default: return {1'b0, 4'b1111, 16'(k)};
    endcase
  endfunction

  int q4[$];
  int q1[$];
  int t4 = -1;
  int t1 = -1;
  logic mon_en = 1'b0;
  logic done4_prev = 1'b0;
  logic done1_prev = 1'b0;

  always @(posedge clock) t4 <= rst4_n ? t4 + 1 : -1;
  always @(posedge clock) t1 <= rst1_n ? t1 + 1 : -1;

  task automatic mon_step(input string tag, input int t, input int n,
                          input logic [20:0] act, input logic prev_done, ref int q[$]);
    check({tag, "_outs"}, 32'(act), 32'(exp_outs(t, n)));
    if (!act[16]) begin
      if (q.size() == 0) check({tag, "_we_extra"}, 32'd1, 32'd0);
      else               check({tag, "_we_addr"}, 32'(act[15:0]), 32'(q.pop_front()));
    end
    if (act[20] && !prev_done) check({tag, "_all_written"}, 32'(q.size()), 32'd0);
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      mon_step("w4", t4, 16, {done4, ecs4, oe4, cs4, we4, addr4}, done4_prev, q4);
      mon_step("w1", t1, 2,  {done1, ecs1, oe1, cs1, we1, addr1}, done1_prev, q1);
      done4_prev = done4;
      done1_prev = done1;
    end
  end

  // Called just after a rising edge; loads the expected write order, then releases reset.
  task automatic release4();
    q4.delete();
    for (int i = 0; i < 16; i++) q4.push_back(i);
    rst4_n = 1'b1;
  endtask

  task automatic release1();
    q1.delete();
    for (int i = 0; i < 2; i++) q1.push_back(i);
    rst1_n = 1'b1;
  endtask

  task automatic wait_done4(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clock); #1;
      if (done4) break;
    end
    check(tag, 32'(done4), 32'd1);
    check({tag, "_edge"}, 32'(t4), 32'd64);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  initial begin
    rst4_n = 1'b0;
    rst1_n = 1'b0;
    @(posedge clock); #1;
    mon_en = 1'b1;
    cycles(10);

    // Full copy on both widths, then a long idle stretch with done held.
    release4();
    release1();
    wait_done4("w4_done_first", 100);
    check("w1_done", 32'(done1), 32'd1);
    cycles(1000);
    check("w4_done_held", 32'(done4), 32'd1);

    // Reset pulse after done: done drops, copy repeats from address 0.
    rst4_n = 1'b0;
    cycles(1);
    release4();
    wait_done4("w4_done_repeat", 100);

    // Reset in the middle of byte 7's WRITE cycle.
    rst4_n = 1'b0;
    cycles(1);
    release4();
    for (int i = 0; i < 200; i++) begin
      @(posedge clock); #1;
      if (t4 == 29) break;
    end
    check("w4_reach_byte7_write", 32'(t4), 32'd29);
    rst4_n = 1'b0;
    cycles(2);
    release4();
    wait_done4("w4_done_restart", 100);
    cycles(20);

    check("w4_queue_drained", 32'(q4.size()), 32'd0);
    check("w1_queue_drained", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
